// File: rtl/gol_generation_sequencer.sv
// ---------------------------------------------------------------------------
// gol_generation_sequencer
//
// Runs N Game-of-Life generations on the engine without HPS involvement.
// Each generation uses the enable/completed handshake. Source and destination
// board buffers swap after every generation, so the newest board alternates
// between base_a and base_b. Progress, the final board address and the
// done/error status are reported back to the HPS PIOs.
//
// Ports
//   clock_i                  system clock
//   reset_i                  asynchronous, active-high reset
//   start_i                  run request (level); a rising edge is accepted only in IDLE
//   abort_i                  cancel the current run; sampled every cycle
//   num_generations_i        generations to run; sampled on an accepted start
//   base_a_i / base_b_i      board buffers; base_a holds the initial board
//   eng_starting_address_o   source board address to the engine
//   eng_result_address_o     destination board address to the engine
//   eng_enable_o             engine run request
//   eng_completed_i          engine completion (level)
//   busy_o                   high in every state except IDLE
//   done_o                   sticky; set when a run finishes successfully
//   error_o                  sticky; set when the watchdog expires
//   gen_count_o              generations completed in the current or last run
//   final_address_o          buffer that holds the latest result board
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module gol_generation_sequencer #(
  parameter int ADDR_W         = 12,
  parameter int GEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [GEN_W-1:0]  num_generations_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  output logic [ADDR_W-1:0] eng_starting_address_o,
  output logic [ADDR_W-1:0] eng_result_address_o,
  output logic              eng_enable_o,
  input  logic              eng_completed_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [GEN_W-1:0]  gen_count_o,
  output logic [ADDR_W-1:0] final_address_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_WAIT_RELEASE,
    S_FINISH,
    S_ERROR
  } state_t;

  // A zero timeout disables the watchdog. TIMER_LAST is then never used.
  localparam bit          WDOG_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                start_q;
  logic [GEN_W-1:0]    num_q, num_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [31:0]         timer_q, timer_d;
  logic [ADDR_W-1:0]   eng_src_q, eng_src_d;
  logic [ADDR_W-1:0]   eng_dst_q, eng_dst_d;
  logic                enable_q, enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic [ADDR_W-1:0]   final_q, final_d;

  logic start_edge;
  logic timeout;

  assign start_edge = start_i & ~start_q;
  assign timeout    = WDOG_EN && (timer_q == TIMER_LAST);

  // State and output registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      // The edge detector resets as if start were already high. A start
      // level held through reset is therefore not taken as a new request.
      start_q   <= 1'b1;
      num_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      timer_q   <= '0;
      eng_src_q <= '0;
      eng_dst_q <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      gen_q     <= '0;
      final_q   <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_i;
      num_q     <= num_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      timer_q   <= timer_d;
      eng_src_q <= eng_src_d;
      eng_dst_q <= eng_dst_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      gen_q     <= gen_d;
      final_q   <= final_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    src_d     = src_q;
    dst_d     = dst_q;
    timer_d   = timer_q;
    eng_src_d = eng_src_q;
    eng_dst_d = eng_dst_q;
    enable_d  = enable_q;
    done_d    = done_q;
    error_d   = error_q;
    gen_d     = gen_q;
    final_d   = final_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          num_d   = num_generations_i;
          src_d   = base_a_i;
          dst_d   = base_b_i;
          done_d  = 1'b0;
          error_d = 1'b0;
          gen_d   = '0;
          if (num_generations_i == '0) begin
            // A zero-generation run completes at once. The initial board is the result.
            done_d  = 1'b1;
            final_d = base_a_i;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        // The addresses and enable load on the same edge. The engine therefore
        // never sees enable together with stale addresses.
        eng_src_d = src_q;
        eng_dst_d = dst_q;
        enable_d  = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (eng_completed_i) begin
          enable_d = 1'b0;
          gen_d    = gen_q + 1'b1;
          src_d    = dst_q;
          dst_d    = src_q;
          final_d  = dst_q;
          timer_d  = '0;
          state_d  = S_WAIT_RELEASE;
        end else if (timeout) begin
          enable_d = 1'b0;
          error_d  = 1'b1;
          state_d  = S_ERROR;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      S_WAIT_RELEASE: begin
        // Wait for the engine to drop completed. A relaunch before then would
        // be seen as the end of the new generation.
        if (!eng_completed_i) begin
          state_d = (gen_q == num_q) ? S_FINISH : S_LAUNCH;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_ERROR: begin
        if (!start_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        enable_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // Abort overrides completion and timeout in the same cycle. The
    // progress and status registers keep their current values.
    if (abort_i && (state_q != S_IDLE)) begin
      enable_d = 1'b0;
      gen_d    = gen_q;
      final_d  = final_q;
      done_d   = done_q;
      error_d  = error_q;
      state_d  = S_IDLE;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  assign eng_starting_address_o = eng_src_q;
  assign eng_result_address_o   = eng_dst_q;
  assign eng_enable_o           = enable_q;
  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign error_o                = error_q;
  assign gen_count_o            = gen_q;
  assign final_address_o        = final_q;

endmodule

// File: tb/tb_gol_generation_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gol_generation_sequencer
//
// Directed and randomised runs of the generation sequencer. A small engine
// responder lives in the serve_gen task. Expected addresses come from the
// ping-pong rule: generation g reads buffer (g even ? A : B) and writes the
// other buffer. Expected timing comes from the handshake cycle counts.
// ---------------------------------------------------------------------------
module tb_gol_generation_sequencer;

  localparam int ADDR_W = 12;
  localparam int GEN_W  = 16;
  localparam int TMO    = 20;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              eng_completed;
  logic [GEN_W-1:0]  num_gen;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;

  logic [ADDR_W-1:0] eng_starting_address_o;
  logic [ADDR_W-1:0] eng_result_address_o;
  logic              eng_enable_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;
  logic [GEN_W-1:0]  gen_count_o;
  logic [ADDR_W-1:0] final_address_o;

  int tests = 0;
  int fails = 0;

  gol_generation_sequencer #(
    .ADDR_W(ADDR_W),
    .GEN_W(GEN_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .start_i(start),
    .abort_i(abort),
    .num_generations_i(num_gen),
    .base_a_i(base_a),
    .base_b_i(base_b),
    .eng_starting_address_o(eng_starting_address_o),
    .eng_result_address_o(eng_result_address_o),
    .eng_enable_o(eng_enable_o),
    .eng_completed_i(eng_completed),
    .busy_o(busy_o),
    .done_o(done_o),
    .error_o(error_o),
    .gen_count_o(gen_count_o),
    .final_address_o(final_address_o)
  );

  always #5 clock = ~clock;

  // Global time limit
  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Buffer read by generation g. Generation g writes buffer_for(a, b, g+1).
  function automatic logic [ADDR_W-1:0] buffer_for(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b,
                                                   input int g);
    return (g % 2 == 0) ? a : b;
  endfunction

  task automatic wait_enable(output int n);
    n = 0;
    while (eng_enable_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Serve one generation. Completion is signalled lat cycles after enable.
  // It is held for hold extra cycles after enable drops.
  task automatic serve_gen(input int g, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                           input int lat, input int hold, input int exp_gap);
    int n;
    wait_enable(n);
    check("launch_gap", n, exp_gap);
    check("src_addr", eng_starting_address_o, buffer_for(a, b, g));
    check("dst_addr", eng_result_address_o, buffer_for(a, b, g + 1));
    repeat (lat - 1) tick();
    check("enable_held", eng_enable_o, 1);
    eng_completed = 1'b1;
    tick();
    check("enable_drop", eng_enable_o, 0);
    check("gen_count", gen_count_o, g + 1);
    check("final_address", final_address_o, buffer_for(a, b, g + 1));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("no_relaunch", eng_enable_o, 0);
    end
    eng_completed = 1'b0;
  endtask

  task automatic do_run(input int n_gen, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                        input int lat, input int hold, input bit keep_high);
    $display("[TB] run N=%0d A=0x%0h B=0x%0h lat=%0d hold=%0d", n_gen, a, b, lat, hold);
    num_gen = GEN_W'(n_gen);
    base_a  = a;
    base_b  = b;
    start   = 1'b1;
    tick();
    check("busy_on_start", busy_o, 1);
    check("done_cleared", done_o, 0);
    check("error_cleared", error_o, 0);
    check("gen_cleared", gen_count_o, 0);
    for (int g = 0; g < n_gen; g++) begin
      serve_gen(g, a, b, lat, hold, (g == 0) ? 1 : 2);
    end
    tick();
    check("finish_busy", busy_o, 1);
    check("finish_done_pending", done_o, 0);
    tick();
    check("run_done", done_o, 1);
    check("run_idle", busy_o, 0);
    check("run_gen_count", gen_count_o, n_gen);
    check("run_final", final_address_o, buffer_for(a, b, n_gen));
    check("run_enable_low", eng_enable_o, 0);
    if (!keep_high) begin
      start = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n;
    logic [ADDR_W-1:0] ra, rb;

    reset = 1'b1; start = 1'b0; abort = 1'b0; eng_completed = 1'b0;
    num_gen = '0; base_a = '0; base_b = '0;
    repeat (3) tick();
    check("rst_enable", eng_enable_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_gen", gen_count_o, 0);
    check("rst_final", final_address_o, 0);
    check("rst_src", eng_starting_address_o, 0);
    check("rst_dst", eng_result_address_o, 0);
    reset = 1'b0;
    tick();

    // Three generations ping-ponging between 0x000 and 0x400
    do_run(3, 12'h000, 12'h400, 10, 0, 0);

    // Zero generations: done at once, nothing launched
    $display("[TB] zero-generation start");
    num_gen = '0; base_a = 12'h123; base_b = 12'h456; start = 1'b1;
    tick();
    check("n0_done", done_o, 1);
    check("n0_final", final_address_o, 12'h123);
    check("n0_busy", busy_o, 0);
    check("n0_gen", gen_count_o, 0);
    tick();
    check("n0_enable", eng_enable_o, 0);
    check("n0_busy2", busy_o, 0);
    start = 1'b0;
    tick();

    // Watchdog: the engine never completes
    $display("[TB] watchdog run");
    num_gen = 16'd2; base_a = 12'h0A0; base_b = 12'h0B0; start = 1'b1;
    tick();
    wait_enable(n);
    check("wd_launch_gap", n, 1);
    repeat (TMO - 1) tick();
    check("wd_enable_before", eng_enable_o, 1);
    check("wd_error_before", error_o, 0);
    tick();
    check("wd_enable_drop", eng_enable_o, 0);
    check("wd_error", error_o, 1);
    check("wd_busy", busy_o, 1);
    tick();
    check("wd_busy_hold", busy_o, 1);
    start = 1'b0;
    tick();
    check("wd_idle", busy_o, 0);
    check("wd_error_sticky", error_o, 1);

    // Abort in the same cycle as completion, during generation 2 of 5
    $display("[TB] abort during gen 2 of 5");
    num_gen = 16'd5; base_a = 12'h100; base_b = 12'h200; start = 1'b1;
    tick();
    check("ab_error_cleared", error_o, 0);
    serve_gen(0, 12'h100, 12'h200, 5, 0, 1);
    wait_enable(n);
    check("ab_launch_gap", n, 2);
    repeat (3) tick();
    eng_completed = 1'b1;
    abort = 1'b1;
    tick();
    check("ab_enable", eng_enable_o, 0);
    check("ab_busy", busy_o, 0);
    check("ab_gen", gen_count_o, 1);
    check("ab_done", done_o, 0);
    check("ab_final", final_address_o, 12'h200);
    abort = 1'b0; eng_completed = 1'b0; start = 1'b0;
    repeat (2) tick();
    check("ab_no_relaunch", eng_enable_o, 0);

    // Completion held for 7 cycles after enable drops
    do_run(2, 12'h300, 12'h700, 4, 7, 0);

    // start held high across the end of a run and through a reset
    do_run(1, 12'h010, 12'h020, 3, 1, 1);
    repeat (5) tick();
    check("hold_no_retrigger", busy_o, 0);
    reset = 1'b1;
    tick();
    check("hold_rst_done", done_o, 0);
    check("hold_rst_final", final_address_o, 0);
    reset = 1'b0;
    repeat (4) tick();
    check("hold_no_start_after_reset", busy_o, 0);
    check("hold_no_enable_after_reset", eng_enable_o, 0);
    start = 1'b0; tick();
    num_gen = '0; start = 1'b1; tick();
    check("n0_done_again", done_o, 1);
    start = 1'b0; tick();
    do_run(2, 12'h040, 12'h080, 2, 0, 0);

    // Asynchronous reset during WAIT_DONE drops enable without a clock edge
    $display("[TB] async reset mid-run");
    num_gen = 16'd3; base_a = 12'h011; base_b = 12'h022; start = 1'b1;
    tick();
    wait_enable(n);
    check("ar_enable_up", eng_enable_o, 1);
    reset = 1'b1;
    #1;
    check("ar_enable_async", eng_enable_o, 0);
    check("ar_busy_async", busy_o, 0);
    tick();
    reset = 1'b0; start = 1'b0;
    tick();

    // Randomised runs
    for (int r = 0; r < 6; r++) begin
      ra = ADDR_W'($urandom);
      rb = ra ^ ADDR_W'($urandom_range(1, (1 << ADDR_W) - 1));
      do_run($urandom_range(1, 4), ra, rb, $urandom_range(1, 12), $urandom_range(0, 6), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
